// File: rtl/btn_move_ctrl_if.sv
// Button/move bundle between the raw push-buttons and the player object.
// The controller owns the slave side; the board/bench owns the master side.
interface btn_move_ctrl_if;
  logic [3:0] btn_raw;
  logic [3:0] btns;
  logic       btnClk2;
  logic [3:0] btn_db;

  modport master (
    output btn_raw,
    input  btns,
    input  btnClk2,
    input  btn_db
  );

  modport slave (
    input  btn_raw,
    output btns,
    output btnClk2,
    output btn_db
  );
endinterface

// File: rtl/btn_move_ctrl.sv
// Push-button front end: synchronize, debounce, pick one direction and
// emit a move tick on press followed by delayed auto-repeat ticks.
module btn_move_ctrl #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 30000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  btn_move_ctrl_if.slave   bus
);

  localparam logic [31:0] DB_MAX = 32'(DB_CYCLES - 1);
  localparam logic [31:0] RD_MAX = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_MAX = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    DELAY,
    REPEAT
  } state_t;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_db;
  logic [31:0] r_dbcnt [4];
  logic [3:0]  w_sel;
  state_t      r_state;
  logic [3:0]  r_btns;
  logic        r_clk2;
  logic [31:0] r_cnt;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: flip only after a run of stable differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db <= '0;
      for (int i = 0; i < 4; i++)
        r_dbcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_MAX) begin
          r_db[i]    <= ~r_db[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 32'd1;
        end
      end
    end
  end

  // Fixed-priority direction pick; several keys may be down at once.
  always_comb begin
    w_sel = '0;
    priority case (1'b1)
      r_db[0]: w_sel = 4'b0001;
      r_db[1]: w_sel = 4'b0010;
      r_db[2]: w_sel = 4'b0100;
      r_db[3]: w_sel = 4'b1000;
      default: w_sel = '0;
    endcase
  end

  // Tick FSM; btns settles a cycle before the tick that uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_btns  <= '0;
      r_clk2  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_clk2 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_btns <= w_sel;
          if (w_sel != 4'b0000)
            r_state <= FIRST;
        end
        FIRST: begin
          if (w_sel == 4'b0000) begin
            r_btns  <= '0;
            r_state <= IDLE;
          end else begin
            r_clk2  <= 1'b1;
            r_cnt   <= RD_MAX;
            r_state <= DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (w_sel == 4'b0000) begin
            r_btns  <= '0;
            r_state <= IDLE;
          end else if (w_sel != r_btns) begin
            r_btns  <= w_sel;
            r_state <= FIRST;
          end else if (r_cnt == 32'd0) begin
            r_clk2  <= 1'b1;
            r_cnt   <= RP_MAX;
            r_state <= REPEAT;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_btns  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.btns    = r_btns;
  assign bus.btnClk2 = r_clk2;
  assign bus.btn_db  = r_db;

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Directed bench for btn_move_ctrl with small debounce/repeat constants.
// Expected cycle positions are counted from the edge after each stimulus.
module tb_btn_move_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic       prev_clk2 = 1'b0;
  logic [3:0] prev_btns = '0;

  btn_move_ctrl_if bus ();

  btn_move_ctrl #(
    .DB_CYCLES    (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic pulse(string tag, logic exp);
    chk(tag, {3'b000, bus.btnClk2}, {3'b000, exp});
  endtask

  task automatic quiet(int n, string tag);
    repeat (n) begin
      tick();
      pulse(tag, 1'b0);
    end
  endtask

  task automatic all_zero(string tag);
    chk({tag, "_btns"}, bus.btns, 4'b0000);
    chk({tag, "_db"}, bus.btn_db, 4'b0000);
    pulse({tag, "_clk2"}, 1'b0);
  endtask

  // Continuous checks on tick spacing and btns stability around ticks.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      assert (!(bus.btnClk2 && prev_clk2)) else begin
        n_fail++;
        $error("FAIL mon_double: got 1,1, want no back-to-back");
      end
      n_tests++;
      assert (!bus.btnClk2 || bus.btns === prev_btns) else begin
        n_fail++;
        $error("FAIL mon_stable: got %b, want %b", bus.btns, prev_btns);
      end
    end
    prev_clk2 = bus.btnClk2;
    prev_btns = bus.btns;
  end

  initial begin
    bus.btn_raw = 4'b0000;
    tick();
    tick();
    all_zero("reset");
    rst = 1'b0;
    tick();

    // Hold up: db at +6, btns at +7, ticks at +8, +18, +23, +28, +33.
    bus.btn_raw = 4'b0001;
    repeat (5) tick();
    chk("up_db_early", bus.btn_db, 4'b0000);
    tick();
    chk("up_db", bus.btn_db, 4'b0001);
    chk("up_btns_early", bus.btns, 4'b0000);
    tick();
    chk("up_btns", bus.btns, 4'b0001);
    pulse("up_nopulse7", 1'b0);
    tick();
    pulse("up_first", 1'b1);
    quiet(9, "up_delay");
    tick();
    pulse("up_rep1", 1'b1);
    quiet(4, "up_per1");
    tick();
    pulse("up_rep2", 1'b1);
    quiet(4, "up_per2");
    tick();
    pulse("up_rep3", 1'b1);
    quiet(3, "up_per3");
    // Release so sel drops exactly when the counter reaches 0 (+38).
    bus.btn_raw = 4'b0000;
    tick();
    tick();
    pulse("up_rep4", 1'b1);
    quiet(3, "rel_wait");
    tick();
    pulse("rel_37", 1'b0);
    chk("rel_btns37", bus.btns, 4'b0001);
    chk("rel_db37", bus.btn_db, 4'b0000);
    tick();
    pulse("rel_expiry", 1'b0);
    chk("rel_btns", bus.btns, 4'b0000);
    quiet(12, "rel_idle");
    chk("rel_idle_btns", bus.btns, 4'b0000);

    // Bounce right every 2 cycles: nothing may get through.
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0)
        bus.btn_raw[3] = ~bus.btn_raw[3];
      tick();
      all_zero("bounce");
    end
    bus.btn_raw = 4'b0000;
    repeat (8) begin
      tick();
      all_zero("bounce_after");
    end

    // Left + right: left wins; dropping left retargets to right.
    bus.btn_raw = 4'b1100;
    repeat (6) tick();
    tick();
    chk("lr_btns", bus.btns, 4'b0100);
    pulse("lr_nopulse", 1'b0);
    tick();
    pulse("lr_first", 1'b1);
    tick();
    pulse("lr_9", 1'b0);
    bus.btn_raw = 4'b1000;
    repeat (6) begin
      tick();
      pulse("lr_hold", 1'b0);
      chk("lr_hold_btns", bus.btns, 4'b0100);
    end
    tick();
    chk("rt_btns", bus.btns, 4'b1000);
    pulse("rt_nopulse", 1'b0);
    tick();
    pulse("rt_first", 1'b1);
    chk("rt_btns_pulse", bus.btns, 4'b1000);
    bus.btn_raw = 4'b0000;
    quiet(6, "rt_rel");
    tick();
    chk("rt_rel_btns", bus.btns, 4'b0000);
    pulse("rt_rel_clk2", 1'b0);
    quiet(6, "rt_idle");

    // Hold down into REPEAT, then reset mid-hold.
    bus.btn_raw = 4'b0010;
    repeat (7) tick();
    tick();
    pulse("dn_first", 1'b1);
    quiet(9, "dn_delay");
    tick();
    pulse("dn_rep1", 1'b1);
    quiet(4, "dn_per1");
    tick();
    pulse("dn_rep2", 1'b1);
    tick();
    rst = 1'b1;
    #1;
    all_zero("rst_async");
    repeat (3) begin
      tick();
      all_zero("rst_hold");
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      pulse("post_rst_quiet", 1'b0);
      chk("post_rst_btns", bus.btns, 4'b0000);
    end
    chk("post_rst_db5", bus.btn_db, 4'b0000);
    tick();
    chk("post_rst_db6", bus.btn_db, 4'b0010);
    pulse("post_rst_6", 1'b0);
    tick();
    chk("post_rst_btns7", bus.btns, 4'b0010);
    pulse("post_rst_7", 1'b0);
    tick();
    pulse("post_rst_first", 1'b1);

    bus.btn_raw = 4'b0000;
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
